// File: rtl/fp16_addsub_pkg.sv
// Shared widths, result payload type and a constant log2 helper for the FPAddSub drain.
package fp16_addsub_pkg;

  localparam int unsigned DWIDTH     = 16;
  localparam int unsigned FLAG_W     = 5;
  localparam int unsigned FP16_TAG_W = 4;

  typedef struct packed {
    logic [DWIDTH-1:0]     result;
    logic [FLAG_W-1:0]     flags;
    logic [FP16_TAG_W-1:0] tag;
  } fp16_res_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp16_sync_fifo.sv
// Synchronous FIFO with natural pointer wrap; the read port shows the head entry,
// or the last popped entry while empty.
module fp16_sync_fifo
  import fp16_addsub_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_last;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A push at full is only taken when the head leaves on the same edge.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        r_last <= '0;
    else if (w_pop) r_last <= r_mem[r_rd_ptr];
  end

  assign o_rd_data = w_empty ? r_last : r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = w_full;

endmodule

// File: rtl/fp16_addsub_drain.sv
// Collects FPAddSub results into a credit-throttled FIFO using a valid/tag delay line.
// Optional FP16_DRAIN_STATS_EN adds saturating pop / exception-pop counters.
module fp16_addsub_drain
  import fp16_addsub_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TAG_W      = FP16_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              issue_ready,
  input  logic [DWIDTH-1:0] fp_result,
  input  logic [FLAG_W-1:0] fp_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic [TAG_W-1:0]  out_tag,
  output logic              drop_err
`ifdef FP16_DRAIN_STATS_EN
  ,
  output logic [15:0]       op_count,
  output logic [15:0]       exc_count
`endif
);

  localparam int unsigned CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam int unsigned INF_W = clog2(PIPE_LAT + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [PIPE_LAT-1:0] r_v;
  logic [TAG_W-1:0]    r_tag [PIPE_LAT];
  logic                r_drop_err;
  logic [INF_W-1:0]    w_inflight;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_capture;
  logic                w_pop;
  fp16_res_t           w_wr_data;
  fp16_res_t           w_rd_data;

  assign w_capture = r_v[PIPE_LAT-1];
  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
      w_inflight = w_inflight + INF_W'(r_v[i]);
    end
  end

  // Credit covers both buffered and in-flight ops so capture never meets a full FIFO.
  assign issue_ready = (SUM_W'(w_count) + SUM_W'(w_inflight)) < SUM_W'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else begin
      r_v[0] <= issue_valid & issue_ready;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        r_v[i] <= r_v[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tag[0] <= issue_tag;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_drop_err <= 1'b0;
    else     r_drop_err <= r_drop_err | (issue_valid & ~issue_ready);
  end
  assign drop_err = r_drop_err;

  always_comb begin
    w_wr_data        = '0;
    w_wr_data.result = fp_result;
    w_wr_data.flags  = fp_flags;
    w_wr_data.tag    = FP16_TAG_W'(r_tag[PIPE_LAT-1]);
  end

  fp16_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fp16_res_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_capture),
    .i_wr_data (w_wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full)
  );

  assign out_result = w_rd_data.result;
  assign out_flags  = w_rd_data.flags;
  assign out_tag    = TAG_W'(w_rd_data.tag);

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_full_write: assert (!(w_capture && w_full && !w_pop));
    end
  end

`ifdef FP16_DRAIN_STATS_EN
  logic [15:0] r_op_count;
  logic [15:0] r_exc_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count  <= '0;
      r_exc_count <= '0;
    end else if (w_pop) begin
      if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
      if ((out_flags != '0) && (r_exc_count != 16'hFFFF)) r_exc_count <= r_exc_count + 16'd1;
    end
  end

  assign op_count  = r_op_count;
  assign exc_count = r_exc_count;
`endif

endmodule
